data_memory_pipe: RTL and testbench
===================================

DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 Parameter ADDR_W, default 32, request address width in bits.
REQ-003 Parameter DEPTH, default 64, number of words stored.
REQ-004 Parameter LATENCY, default 2, cycles from request acceptance to response valid; legal range 1..4.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_wr  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  word index.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 req_be  input  DATA_W/8  byte enables for writes; bit i covers byte i.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-016 rsp_err  output  1  request address out of range.

Function
REQ-017 FSM states: IDLE, WAIT, RESP; exactly one transaction outstanding at a time.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-019 On acceptance: IDLE -> WAIT, latency counter loaded with LATENCY-1, and req_wr, address, data, and be captured.
REQ-020 WAIT decrements the counter each cycle; at 0 -> RESP; rsp_valid rises exactly LATENCY cycles after the accepting edge (for LATENCY=1, WAIT lasts zero cycles and the FSM enters RESP directly).
REQ-021 RESP holds rsp_valid, rsp_rdata, and rsp_err stable until an edge with rsp_ready=1, then -> IDLE; req_ready is 0 during that edge (no same-cycle turnaround).
REQ-022 In-range write (addr < DEPTH): bytes with be=1 updated at the accepting edge, other bytes unchanged; be=0 still produces a response.
REQ-023 Read data is the word content at the accepting edge, so a write accepted earlier is always visible to a later read.
REQ-024 Out-of-range (addr >= DEPTH, full ADDR_W compared): no memory access, rsp_err=1, rsp_rdata=0.
REQ-025 Writes produce a response with rsp_rdata=0 and rsp_err set per REQ-024.
REQ-026 Inputs are ignored outside IDLE; rsp_ready is ignored outside RESP.
REQ-027 Minimum transaction period is LATENCY+1 cycles.

Reset
REQ-028 While rst=1 at an edge: FSM -> IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready=1 in the first cycle after rst deasserts.
REQ-029 Reset SHALL NOT clear memory contents; initial contents are zero-filled at simulation start.
REQ-030 Reset mid-transaction discards the pending response; a write already accepted stays committed.
REQ-031 A request with req_valid=1 on the same edge as rst=1 is not accepted.

Verification
REQ-032 LATENCY=2: write addr 3 data 0xDEADBEEF be=0xF, then read addr 3 -> rsp_valid exactly 2 cycles after acceptance, rdata=0xDEADBEEF, err=0.
REQ-033 Partial write addr 3 data 0x000000AA be=0x1 over 0xDEADBEEF, then read -> rdata=0xDEADBEAA.
REQ-034 Read addr 64 with DEPTH=64 -> err=1, rdata=0, and memory unchanged at all indices.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready=0 throughout; raise rsp_ready -> IDLE on the next edge.
REQ-036 Assert rst while in WAIT after a write of 0x1234 to addr 7 -> no response, req_ready=1 after reset, and a subsequent read of addr 7 returns 0x1234.
REQ-037 Sweep LATENCY=1 and 4 -> measured accept-to-rsp_valid distance equals LATENCY.

Source files
------------

// File: rtl/data_memory_pipe.sv
// Single-outstanding request/response word memory with byte-enabled writes
// and a fixed request-to-response latency.
module data_memory_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);
  localparam int NB = DATA_W / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [1:0]      cnt, cnt_nxt;
  logic            accept, in_range;
  logic [AW-1:0]   idx;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign in_range  = req_addr < ADDR_W'(DEPTH);
  assign idx       = req_addr[AW-1:0];

  // RESP is entered on the edge where the counter reaches zero, so the
  // consumer can take the response exactly LATENCY edges after acceptance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept) begin
        cnt_nxt   = 2'(LATENCY - 1);
        state_nxt = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_nxt = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
        if (cnt <= 2'd1) state_nxt = RESP;
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        rsp_rdata <= (!req_wr && in_range) ? mem[idx] : '0;
        rsp_err   <= !in_range;
      end
    end
  end

  // Memory contents survive reset; only accepted in-range writes touch it.
  always_ff @(posedge clk) begin
    if (!rst && accept && req_wr && in_range) begin
      for (int i = 0; i < NB; i++)
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench: vector table on a LATENCY=2 instance plus hand sequences
// for backpressure, reset and LATENCY=1/4 instances.
module tb_data_memory_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rv[3], rw[3], rsr[3], rqr[3], rsv[3], rse[3];
  logic [31:0] ra[3], wd[3], rsd[3];
  logic [3:0]  be[3];

  int nchk = 0;
  int nfail = 0;

  data_memory_pipe #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rqr[0]), .req_wr(rw[0]),
    .req_addr(ra[0]), .req_wdata(wd[0]), .req_be(be[0]), .rsp_valid(rsv[0]),
    .rsp_ready(rsr[0]), .rsp_rdata(rsd[0]), .rsp_err(rse[0]));
  data_memory_pipe #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rqr[1]), .req_wr(rw[1]),
    .req_addr(ra[1]), .req_wdata(wd[1]), .req_be(be[1]), .rsp_valid(rsv[1]),
    .rsp_ready(rsr[1]), .rsp_rdata(rsd[1]), .rsp_err(rse[1]));
  data_memory_pipe #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rqr[2]), .req_wr(rw[2]),
    .req_addr(ra[2]), .req_wdata(wd[2]), .req_be(be[2]), .rsp_valid(rsv[2]),
    .rsp_ready(rsr[2]), .rsp_rdata(rsd[2]), .rsp_err(rse[2]));

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request on instance d, measure edges to rsp_valid, then consume.
  task automatic txn(input int d, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] b,
                     output logic [31:0] rd, output logic er, output int lat);
    int w;
    lat = 0; rd = '0; er = 1'b0; w = 0;
    while (!rqr[d] && w < 20) begin @(posedge clk); #1; w++; end
    if (!rqr[d]) begin
      nchk++; nfail++;
      $display("FAIL ready_timeout dut%0d: got 0 expected 1", d);
      return;
    end
    rv[d] = 1'b1; rw[d] = wr; ra[d] = addr; wd[d] = wdata; be[d] = b;
    @(posedge clk); #1;
    rv[d] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rsv[d]) begin lat = k; break; end
    end
    if (lat == 0) return;
    rd = rsd[d]; er = rse[d];
    rsr[d] = 1'b1;
    @(posedge clk); #1;
    rsr[d] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    vecs[0]  = '{1'b1, 32'd3,          32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'd3,          32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'd3,          32'h000000AA, 4'h1, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'd3,          32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    vecs[4]  = '{1'b0, 32'd64,         32'h0,        4'h0, 32'h0,        1'b1};
    vecs[5]  = '{1'b1, 32'd64,         32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 32'd63,         32'h0,        4'h0, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 32'd63,         32'h11223344, 4'h0, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'd63,         32'h0,        4'h0, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 32'd5,          32'hA5A5A5A5, 4'hC, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'd5,          32'h0,        4'h0, 32'hA5A50000, 1'b0};
    vecs[11] = '{1'b0, 32'h80000003,   32'h0,        4'h0, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 32'd3,          32'h0,        4'h0, 32'hDEADBEAA, 1'b0};

    for (int d = 0; d < 3; d++) begin
      rv[d] = 0; rw[d] = 0; rsr[d] = 0; ra[d] = '0; wd[d] = '0; be[d] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsv[0]), 32'd0);
    chk("rst_rsp_err",   32'(rse[0]), 32'd0);
    chk("rst_rsp_rdata", rsd[0],      32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(rqr[0]), 32'd1);

    // Table-driven transactions on the LATENCY=2 instance
    for (int i = 0; i < 13; i++) begin
      txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      chk($sformatf("vec%0d_lat", i),   32'(lat), 32'd2);
      chk($sformatf("vec%0d_rdata", i), rd,       vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i),   32'(er),  32'(vecs[i].exp_err));
    end

    // Backpressure: response held stable while rsp_ready is low
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'd3;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    @(negedge clk);
    chk("bp_not_early", 32'(rsv[0]), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", c), 32'(rsv[0]), 32'd1);
      chk($sformatf("bp_rdata_%0d", c), rsd[0],      32'hDEADBEAA);
      chk($sformatf("bp_ready_%0d", c), 32'(rqr[0]), 32'd0);
    end
    rsr[0] = 1'b1;
    @(posedge clk); #1;
    rsr[0] = 1'b0;
    chk("bp_release_valid", 32'(rsv[0]), 32'd0);
    chk("bp_release_ready", 32'(rqr[0]), 32'd1);

    // Reset while in WAIT after an accepted write
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'd7; wd[0] = 32'h1234; be[0] = 4'hF;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", 32'(rqr[0]), 32'd1);
    chk("midrst_valid", 32'(rsv[0]), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_rsp", 32'(rsv[0]), 32'd0);
    txn(0, 1'b0, 32'd7, 32'h0, 4'h0, rd, er, lat);
    chk("midrst_read7", rd, 32'h1234);

    // A request coincident with reset is not accepted
    @(negedge clk);
    rst = 1'b1;
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'd10; wd[0] = 32'hFFFFFFFF; be[0] = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0; rv[0] = 1'b0;
    chk("rstreq_ready", 32'(rqr[0]), 32'd1);
    txn(0, 1'b0, 32'd10, 32'h0, 4'h0, rd, er, lat);
    chk("rstreq_read10", rd, 32'h0);

    // LATENCY sweep on the 1 and 4 instances
    for (int d = 1; d < 3; d++) begin
      txn(d, 1'b1, 32'd9, 32'hCAFEF00D, 4'hF, rd, er, lat);
      chk($sformatf("sweep%0d_wlat", d), 32'(lat), (d == 1) ? 32'd1 : 32'd4);
      txn(d, 1'b0, 32'd9, 32'h0, 4'h0, rd, er, lat);
      chk($sformatf("sweep%0d_rlat", d),  32'(lat), (d == 1) ? 32'd1 : 32'd4);
      chk($sformatf("sweep%0d_rdata", d), rd,       32'hCAFEF00D);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
